// File: rtl/hex_ascii_tx.sv
// hex_ascii_tx
// Captures a packed word of ASCII hex characters and streams it out one byte
// at a time, most-significant character first. An optional CR/LF can follow.
// Leading '0' characters can optionally be skipped.
//
// Ports
//   I_CLK    in   1   clock
//   I_RSTF   in   1   asynchronous active-low reset
//   I_HEX    in   32  packed chars {c3,c2,c1,c0}, sampled only on an accepted start
//   I_START  in   1   single-cycle request to send I_HEX
//   O_DATA   out  8   current output byte (8'h00 when idle)
//   O_VALID  out  1   O_DATA valid
//   I_READY  in   1   consumer ready
//   O_BUSY   out  1   word in progress
//   O_DONE   out  1   one-cycle pulse the cycle after the final byte transfers
//   O_DROP   out  1   one-cycle pulse: a start arrived while busy and was ignored
//   O_STATE  out  2   debug view of the FSM state (0 idle, 1 char, 2 cr, 3 lf)
//
// Handshake: a byte transfers at a rising edge where O_VALID and I_READY are
// both high. While O_VALID is high and I_READY is low, O_DATA and O_VALID stay
// stable. O_VALID never drops inside a word, and the next byte is presented
// the cycle after a transfer, so a consumer holding I_READY high gets one byte
// per cycle.

module hex_ascii_tx #(
   parameter int NUM_CHARS      = 4,
   parameter bit ADD_CRLF       = 1'b1,
   parameter bit SUPPRESS_ZEROS = 1'b0
) (
   input  logic        I_CLK,
   input  logic        I_RSTF,
   input  logic [31:0] I_HEX,
   input  logic        I_START,
   output logic [7:0]  O_DATA,
   output logic        O_VALID,
   input  logic        I_READY,
   output logic        O_BUSY,
   output logic        O_DONE,
   output logic        O_DROP,
   output logic [1:0]  O_STATE
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CHAR = 2'd1,
      ST_CR   = 2'd2,
      ST_LF   = 2'd3
   } state_t;

   localparam logic [1:0] LAST_IDX = 2'(NUM_CHARS - 1);

   state_t      state_q, state_d;
   logic [31:0] hex_q, hex_d;
   logic [1:0]  idx_q, idx_d;
   logic        done_q, done_d;
   logic        drop_q, drop_d;

   logic [1:0]  first_idx;
   logic        found;
   logic        xfer;

   // Starting character index, resolved straight from I_HEX so skipped
   // leading zeros cost no cycles. Index 0 is always sent even if it is '0'.
   always_comb begin
      first_idx = LAST_IDX;
      found     = 1'b0;
      if (SUPPRESS_ZEROS) begin
         first_idx = 2'd0;
         for (int i = 3; i >= 1; i--) begin
            if ((i <= NUM_CHARS - 1) && !found && (I_HEX[8*i +: 8] != 8'h30)) begin
               first_idx = 2'(i);
               found     = 1'b1;
            end
         end
      end
   end

   assign xfer = O_VALID & I_READY;

   // State register
   always_ff @(posedge I_CLK or negedge I_RSTF) begin
      if (!I_RSTF) begin
         state_q <= ST_IDLE;
         hex_q   <= 32'h0;
         idx_q   <= 2'd0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hex_q   <= hex_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      hex_d   = hex_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      // A start is only ignored while a word is in flight; the DONE cycle is
      // already idle, so a start there is accepted.
      drop_d  = I_START && (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (I_START) begin
               state_d = ST_CHAR;
               hex_d   = I_HEX;
               idx_d   = first_idx;
            end
         end
         ST_CHAR: begin
            if (xfer) begin
               if (idx_q == 2'd0) begin
                  if (ADD_CRLF) begin
                     state_d = ST_CR;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  idx_d = idx_q - 2'd1;
               end
            end
         end
         ST_CR: begin
            if (xfer) state_d = ST_LF;
         end
         ST_LF: begin
            if (xfer) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: everything decodes from registered state, so reset
   // drives the outputs to their idle values immediately.
   always_comb begin
      O_DATA  = 8'h00;
      O_VALID = 1'b0;
      O_BUSY  = 1'b0;
      case (state_q)
         ST_CHAR: begin
            O_DATA  = hex_q[{idx_q, 3'b000} +: 8];
            O_VALID = 1'b1;
            O_BUSY  = 1'b1;
         end
         ST_CR: begin
            O_DATA  = 8'h0D;
            O_VALID = 1'b1;
            O_BUSY  = 1'b1;
         end
         ST_LF: begin
            O_DATA  = 8'h0A;
            O_VALID = 1'b1;
            O_BUSY  = 1'b1;
         end
         default: begin
            O_DATA  = 8'h00;
            O_VALID = 1'b0;
            O_BUSY  = 1'b0;
         end
      endcase
   end

   assign O_DONE  = done_q;
   assign O_DROP  = drop_q;
   assign O_STATE = state_q;

endmodule

// File: tb/tb_hex_ascii_tx.sv
module tb_hex_ascii_tx;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstf_a, rstf_bc;

   // instance a: defaults (4 chars, CRLF, no suppression)
   logic [31:0] hex_a;   logic start_a, ready_a;
   logic [7:0]  data_a;  logic valid_a, busy_a, done_a, drop_a;  logic [1:0] st_a;
   // instance b: leading-zero suppression
   logic [31:0] hex_b;   logic start_b, ready_b;
   logic [7:0]  data_b;  logic valid_b, busy_b, done_b, drop_b;  logic [1:0] st_b;
   // instance c: 2 chars, no CRLF
   logic [31:0] hex_c;   logic start_c, ready_c;
   logic [7:0]  data_c;  logic valid_c, busy_c, done_c, drop_c;  logic [1:0] st_c;

   hex_ascii_tx u_a (
      .I_CLK(clk), .I_RSTF(rstf_a), .I_HEX(hex_a), .I_START(start_a),
      .O_DATA(data_a), .O_VALID(valid_a), .I_READY(ready_a), .O_BUSY(busy_a),
      .O_DONE(done_a), .O_DROP(drop_a), .O_STATE(st_a));

   hex_ascii_tx #(.NUM_CHARS(4), .ADD_CRLF(1'b1), .SUPPRESS_ZEROS(1'b1)) u_b (
      .I_CLK(clk), .I_RSTF(rstf_bc), .I_HEX(hex_b), .I_START(start_b),
      .O_DATA(data_b), .O_VALID(valid_b), .I_READY(ready_b), .O_BUSY(busy_b),
      .O_DONE(done_b), .O_DROP(drop_b), .O_STATE(st_b));

   hex_ascii_tx #(.NUM_CHARS(2), .ADD_CRLF(1'b0), .SUPPRESS_ZEROS(1'b0)) u_c (
      .I_CLK(clk), .I_RSTF(rstf_bc), .I_HEX(hex_c), .I_START(start_c),
      .O_DATA(data_c), .O_VALID(valid_c), .I_READY(ready_c), .O_BUSY(busy_c),
      .O_DONE(done_c), .O_DROP(drop_c), .O_STATE(st_c));

   // ---------------- scoreboard ----------------
   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   logic [7:0] exp_c[$];

   int tests = 0, fails = 0;         // stimulus-side comparisons
   int mon_tests = 0, mon_fails = 0; // monitor-side comparisons
   int done_cnt_a = 0;

   logic       stall_a = 1'b0;
   logic [7:0] stall_data_a = 8'h00;

   // Monitor: samples on the falling edge, i.e. what the next rising edge sees.
   always @(negedge clk) begin
      logic [7:0] e;
      if (done_a) done_cnt_a <= done_cnt_a + 1;
      // a: stability across stalls, then byte transfers
      if (stall_a) begin
         mon_tests++;
         if (!valid_a || data_a !== stall_data_a) begin
            mon_fails++;
            $display("FAIL stall_a: got valid=%0b data=%h, required valid=1 data=%h",
                     valid_a, data_a, stall_data_a);
         end
      end
      stall_a      <= valid_a && !ready_a && rstf_a;
      stall_data_a <= data_a;
      if (valid_a && ready_a) begin
         mon_tests++;
         if (exp_a.size() == 0) begin
            mon_fails++;
            $display("FAIL byte_a: got %h, required no byte", data_a);
         end else begin
            e = exp_a.pop_front();
            if (data_a !== e) begin
               mon_fails++;
               $display("FAIL byte_a: got %h, required %h", data_a, e);
            end
         end
      end
      if (valid_b && ready_b) begin
         mon_tests++;
         if (exp_b.size() == 0) begin
            mon_fails++;
            $display("FAIL byte_b: got %h, required no byte", data_b);
         end else begin
            e = exp_b.pop_front();
            if (data_b !== e) begin
               mon_fails++;
               $display("FAIL byte_b: got %h, required %h", data_b, e);
            end
         end
      end
      if (valid_c && ready_c) begin
         mon_tests++;
         if (exp_c.size() == 0) begin
            mon_fails++;
            $display("FAIL byte_c: got %h, required no byte", data_c);
         end else begin
            e = exp_c.pop_front();
            if (data_c !== e) begin
               mon_fails++;
               $display("FAIL byte_c: got %h, required %h", data_c, e);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Each start task returns #1 into cycle 1 of the word.
   task automatic send_a(input logic [31:0] h);
      hex_a = h; start_a = 1'b1; tick(); start_a = 1'b0;
   endtask
   task automatic send_b(input logic [31:0] h);
      hex_b = h; start_b = 1'b1; tick(); start_b = 1'b0;
   endtask
   task automatic send_c(input logic [31:0] h);
      hex_c = h; start_c = 1'b1; tick(); start_c = 1'b0;
   endtask

   task automatic push_a(input logic [31:0] h);
      for (int i = 3; i >= 0; i--) exp_a.push_back(h[8*i +: 8]);
      exp_a.push_back(8'h0D);
      exp_a.push_back(8'h0A);
   endtask

   task automatic wait_idle_a(input string name);
      for (int i = 0; i < 60; i++) begin
         if (!busy_a) break;
         tick();
      end
      chk(name, {31'h0, busy_a}, 32'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int d0;
      rstf_a = 1'b0; rstf_bc = 1'b0;
      hex_a = '0; hex_b = '0; hex_c = '0;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
      repeat (3) tick();
      chk("rst_data",  {24'h0, data_a}, 32'h0);
      chk("rst_valid", {31'h0, valid_a}, 32'h0);
      chk("rst_busy",  {31'h0, busy_a}, 32'h0);
      chk("rst_flags", {30'h0, done_a, drop_a}, 32'h0);
      rstf_a = 1'b1; rstf_bc = 1'b1;
      repeat (2) tick();

      // 1: full-rate word, bytes on cycles 1..6, DONE on cycle 7
      push_a(32'h31326166);
      send_a(32'h31326166);
      for (int c = 1; c <= 6; c++) begin
         chk($sformatf("t1_valid_c%0d", c), {30'h0, valid_a, busy_a}, 32'h3);
         if (c < 6) tick();
      end
      tick();
      chk("t1_done_c7", {29'h0, done_a, valid_a, busy_a}, 32'h4);
      tick();
      chk("t1_done_pulse", {31'h0, done_a}, 32'h0);
      chk("t1_q_empty", exp_a.size(), 32'h0);

      // 2: READY toggling; stability is checked by the monitor
      ready_a = 1'b0;
      push_a(32'h31326166);
      send_a(32'h31326166);
      d0 = done_cnt_a;
      for (int c = 0; c < 40; c++) begin
         if (done_a) break;
         chk("t2_busy", {31'h0, busy_a}, 32'h1);
         tick();
         ready_a = ~ready_a;
      end
      chk("t2_done_seen", {31'h0, done_a}, 32'h1);
      ready_a = 1'b1;
      tick();
      chk("t2_q_empty", exp_a.size(), 32'h0);

      // 4: second start during byte 2 is dropped
      d0 = done_cnt_a;
      push_a(32'h31326166);
      send_a(32'h31326166);
      tick();                               // cycle 2, byte 32 on the bus
      chk("t4_byte2", {24'h0, data_a}, 32'h32);
      hex_a = 32'h41414141; start_a = 1'b1;
      tick();                               // cycle 3
      start_a = 1'b0;
      chk("t4_drop", {31'h0, drop_a}, 32'h1);
      tick();
      chk("t4_drop_pulse", {31'h0, drop_a}, 32'h0);
      wait_idle_a("t4_idle");
      repeat (3) tick();
      chk("t4_one_done", done_cnt_a - d0, 32'h1);
      chk("t4_q_empty", exp_a.size(), 32'h0);

      // 5: reset mid-word after the second transfer
      d0 = done_cnt_a;
      push_a(32'h31326166);
      send_a(32'h31326166);
      tick(); tick();                       // two transfers done, cycle 3
      rstf_a = 1'b0;
      exp_a.delete();                       // remaining bytes are discarded
      #1;
      chk("t5_rst_valid", {31'h0, valid_a}, 32'h0);
      chk("t5_rst_busy",  {31'h0, busy_a}, 32'h0);
      chk("t5_rst_data",  {24'h0, data_a}, 32'h0);
      tick();
      rstf_a = 1'b1;
      tick(); tick();
      chk("t5_no_done", done_cnt_a - d0, 32'h0);
      push_a(32'h61626364);
      send_a(32'h61626364);
      wait_idle_a("t5_idle");
      tick();
      chk("t5_q_empty", exp_a.size(), 32'h0);

      // 3: leading-zero suppression
      exp_b.push_back(8'h61); exp_b.push_back(8'h0D); exp_b.push_back(8'h0A);
      send_b(32'h30303061);
      chk("t3_first", {24'h0, data_b}, 32'h61);
      tick(); tick(); tick();
      chk("t3_done", {30'h0, done_b, valid_b}, 32'h2);
      exp_b.push_back(8'h30); exp_b.push_back(8'h0D); exp_b.push_back(8'h0A);
      send_b(32'h30303030);
      chk("t3_zero_first", {24'h0, data_b}, 32'h30);
      tick(); tick(); tick();
      chk("t3_zero_done", {30'h0, done_b, valid_b}, 32'h2);
      tick();
      chk("t3_q_empty", exp_b.size(), 32'h0);

      // 6: two chars, no CRLF, back-to-back start on the DONE cycle
      exp_c.push_back(8'h62); exp_c.push_back(8'h65);
      send_c(32'hFFFF6265);
      tick();                               // cycle 2: 65
      chk("t6_second", {24'h0, data_c}, 32'h65);
      tick();                               // cycle 3: DONE
      chk("t6_done", {29'h0, done_c, valid_c, busy_c}, 32'h4);
      exp_c.push_back(8'h41); exp_c.push_back(8'h42);
      hex_c = 32'h00004142; start_c = 1'b1;
      tick();
      start_c = 1'b0;
      chk("t6_b2b_accept", {29'h0, drop_c, valid_c, busy_c}, 32'h3);
      tick(); tick();
      chk("t6_b2b_done", {31'h0, done_c}, 32'h1);
      tick();
      chk("t6_q_empty", exp_c.size(), 32'h0);

      // ---------------- report ----------------
      repeat (2) tick();
      tests += mon_tests;
      fails += mon_fails;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required end of stimulus");
      $fatal(1, "watchdog");
   end

endmodule
